// File: rtl/frame_stream_source.sv
// frame_stream_source
//
// Walks a frame buffer in raster order and streams its pixels to a downstream
// stage as a valid/ready stream framed by sop/eop markers. Read data returns
// one cycle after each read strobe and lands in a 2-entry output FIFO whose
// head drives the stream outputs.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous active-low reset (release synchronized internally)
//   enable     : level, requests continuous frame streaming
//   rd_addr    : frame-buffer read address
//   rd_en      : read strobe; rd_data is valid exactly one cycle later
//   rd_data    : RGB444 pixel returned by the frame buffer
//   ready_in   : downstream back pressure (ready latency 0)
//   data_out   : pixel to the downstream stage
//   sop_out    : first pixel of a frame
//   eop_out    : last pixel of a frame
//   valid_out  : data_out/sop_out/eop_out are valid
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
//
// Parameters
//   WIDTH, HEIGHT : frame geometry in pixels and lines
//   ADDR_W        : address width, 2**ADDR_W must cover WIDTH*HEIGHT

module frame_stream_source #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [11:0]       rd_data,
  input  logic              ready_in,
  output logic [11:0]       data_out,
  output logic              sop_out,
  output logic              eop_out,
  output logic              valid_out,
  output logic              frame_done
);

  localparam int unsigned       NumPix   = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              tag_sop_q, tag_sop_d;
  logic              tag_eop_q, tag_eop_d;
  logic [1:0]        rst_sync_q, rst_sync_d;

  logic [11:0]       fifo_data_q [2];
  logic [11:0]       fifo_data_d [2];
  logic              fifo_sop_q  [2];
  logic              fifo_sop_d  [2];
  logic              fifo_eop_q  [2];
  logic              fifo_eop_d  [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              push;
  logic              pop;
  logic [1:0]        occ_after_pop;

  // ---------------------------------------------------------------------------
  // Output stage: head of the FIFO drives the stream
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_out     = (count_q != 2'd0);
    data_out      = valid_out ? fifo_data_q[rd_ptr_q] : 12'd0;
    sop_out       = valid_out & fifo_sop_q[rd_ptr_q];
    eop_out       = valid_out & fifo_eop_q[rd_ptr_q];
    pop           = valid_out & ready_in;
    push          = inflight_q;
    // Occupancy once this cycle's pop has left. Budgeting reads against this
    // instead of the raw count is what allows one pixel per cycle; it does put
    // ready_in on a combinational path to rd_en.
    occ_after_pop = count_q - {1'b0, pop};
  end

  // ---------------------------------------------------------------------------
  // Read sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tag_sop_d  = tag_sop_q;
    tag_eop_d  = tag_eop_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Hold off until the reset release has passed through the synchronizer.
        if (enable && rst_sync_q[1]) begin
          state_d = StStream;
          addr_d  = '0;
        end
      end

      StStream: begin
        if ((occ_after_pop + {1'b0, inflight_q}) < 2'd2) begin
          rd_en     = 1'b1;
          tag_sop_d = (addr_q == '0);
          tag_eop_d = (addr_q == LastAddr);
          if (addr_q == LastAddr) begin
            // Counter parks on the last address; it never wraps mid-frame.
            state_d = StDrain;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      StDrain: begin
        // enable is only sampled here, so dropping it mid-frame never
        // truncates the frame in progress.
        if ((count_q == 2'd0) && !inflight_q) begin
          frame_done = 1'b1;
          if (enable) begin
            state_d = StStream;
            addr_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign rd_addr    = addr_q;
  assign inflight_d = rd_en;
  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  // ---------------------------------------------------------------------------
  // Output FIFO next state. Entries are written the cycle after their read,
  // carrying the sop/eop tags captured when the read was issued.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_sop_d  = fifo_sop_q;
    fifo_eop_d  = fifo_eop_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (push) begin
      fifo_data_d[wr_ptr_q] = rd_data;
      fifo_sop_d[wr_ptr_q]  = tag_sop_q;
      fifo_eop_d[wr_ptr_q]  = tag_eop_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Simultaneous push and pop leaves the count unchanged.
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      tag_sop_q      <= 1'b0;
      tag_eop_q      <= 1'b0;
      rst_sync_q     <= 2'b00;
      fifo_data_q[0] <= 12'd0;
      fifo_data_q[1] <= 12'd0;
      fifo_sop_q[0]  <= 1'b0;
      fifo_sop_q[1]  <= 1'b0;
      fifo_eop_q[0]  <= 1'b0;
      fifo_eop_q[1]  <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      inflight_q     <= inflight_d;
      tag_sop_q      <= tag_sop_d;
      tag_eop_q      <= tag_eop_d;
      rst_sync_q     <= rst_sync_d;
      fifo_data_q[0] <= fifo_data_d[0];
      fifo_data_q[1] <= fifo_data_d[1];
      fifo_sop_q[0]  <= fifo_sop_d[0];
      fifo_sop_q[1]  <= fifo_sop_d[1];
      fifo_eop_q[0]  <= fifo_eop_d[0];
      fifo_eop_q[1]  <= fifo_eop_d[1];
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_frame_stream_source.sv
// Bench for frame_stream_source with a 4x2 frame and a frame buffer whose
// content equals its address. Expected beats are queued when a frame is
// requested and compared as the DUT hands them over.

module tb_frame_stream_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  rd_addr;
  logic        rd_en;
  logic [11:0] rd_data = 12'd0;
  logic        ready_in;
  logic [11:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        valid_out;
  logic        frame_done;

  always #5 clk = ~clk;

  frame_stream_source #(
    .WIDTH (4),
    .HEIGHT(2),
    .ADDR_W(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .valid_out (valid_out),
    .frame_done(frame_done)
  );

  // Frame buffer: one-cycle read latency, content = address.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 12'(rd_addr);
  end

  int          n_err = 0;
  int          n_checks = 0;
  int          cyc = 0;
  int          rd_en_cnt = 0;
  int          last_eop_cyc = 0;
  logic [13:0] sb[$];
  int          beat_cyc[$];
  int          fd_cyc[$];

  logic        s_rd_en = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = 12'd0;
  logic        s_sop = 1'b0;
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b1;
  logic [11:0] p_data = 12'd0;
  logic        p_sop = 1'b0;
  logic        p_eop = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic push_frame();
    for (int a = 0; a < 8; a++) sb.push_back({12'(a), a == 0, a == 7});
  endtask

  task automatic clear_logs();
    sb.delete();
    beat_cyc.delete();
    fd_cyc.delete();
    rd_en_cnt = 0;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven,
  // samples mid-phase, then advances to the next falling edge.
  task automatic tick();
    logic [13:0] want;
    #2;
    s_rd_en = rd_en;
    s_valid = valid_out;
    s_data  = data_out;
    s_sop   = sop_out;
    if (rd_en) rd_en_cnt++;
    if (frame_done) fd_cyc.push_back(cyc);
    if (p_valid && !p_ready)
      check("hold", 32'({valid_out, data_out, sop_out, eop_out}),
            32'({p_valid, p_data, p_sop, p_eop}));
    if (valid_out && ready_in) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(valid_out), 32'd0);
      end else begin
        want = sb.pop_front();
        check("beat", 32'({data_out, sop_out, eop_out}), 32'(want));
      end
      beat_cyc.push_back(cyc);
      if (eop_out) last_eop_cyc = cyc;
    end
    p_valid = valid_out;
    p_ready = ready_in;
    p_data  = data_out;
    p_sop   = sop_out;
    p_eop   = eop_out;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_rd_en(input string tag);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!s_rd_en && i < 20);
    check(tag, 32'(s_rd_en), 32'd1);
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while (sb.size() != 0 && i < 100) begin
      tick();
      i++;
    end
    check(tag, sb.size(), 0);
    repeat (6) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    ready_in = 1'b0;
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_sop", 32'(sop_out), 32'd0);
    check("rst_eop", 32'(eop_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);

    // Free flow, release synchronization and first-pixel latency
    clear_logs();
    push_frame();
    reset    = 1'b1;
    enable   = 1'b1;
    ready_in = 1'b1;
    tick();
    tick();
    check("rd_en_after_first_edge", 32'(s_rd_en), 32'd0);
    wait_rd_en("ff_start");
    enable = 1'b0;
    tick();
    check("ff_lat_cycle1_valid", 32'(s_valid), 32'd0);
    tick();
    check("ff_lat_cycle2_valid", 32'(s_valid), 32'd1);
    check("ff_lat_cycle2_sop", 32'(s_sop), 32'd1);
    drain("ff_drain");
    check("ff_beats", beat_cyc.size(), 8);
    check("ff_consecutive", beat_cyc[7] - beat_cyc[0], 7);
    check("ff_frame_done_count", fd_cyc.size(), 1);
    check("ff_frame_done_time", fd_cyc[0], last_eop_cyc + 1);
    repeat (5) tick();
    check("ff_idle_rd_en", rd_en_cnt, 8);

    // Back pressure: ready toggles every cycle
    clear_logs();
    push_frame();
    enable = 1'b1;
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      ready_in = (i % 2 == 0);
      tick();
      if (s_rd_en) enable = 1'b0;
    end
    check("bp_drained", sb.size(), 0);
    check("bp_beats", beat_cyc.size(), 8);
    ready_in = 1'b1;
    repeat (6) tick();
    check("bp_frame_done", fd_cyc.size(), 1);

    // Stall with the FIFO full
    clear_logs();
    push_frame();
    ready_in = 1'b0;
    enable   = 1'b1;
    wait_rd_en("stall_start");
    enable = 1'b0;
    repeat (10) tick();
    check("stall_rd_en_cnt", rd_en_cnt, 2);
    check("stall_valid", 32'(s_valid), 32'd1);
    check("stall_head_data", 32'(s_data), 32'd0);
    check("stall_no_beats", beat_cyc.size(), 0);
    ready_in = 1'b1;
    drain("stall_drain");
    check("stall_beats", beat_cyc.size(), 8);
    check("stall_gapless_012", beat_cyc[2] - beat_cyc[0], 2);
    check("stall_gapless_all", beat_cyc[7] - beat_cyc[0], 7);

    // Enable dropped after beat 3
    clear_logs();
    push_frame();
    enable = 1'b1;
    for (int i = 0; i < 40 && beat_cyc.size() < 4; i++) tick();
    enable = 1'b0;
    check("endrop_at_beat3", beat_cyc.size(), 4);
    drain("endrop_drain");
    check("endrop_beats", beat_cyc.size(), 8);
    repeat (8) tick();
    check("endrop_frame_done", fd_cyc.size(), 1);
    check("endrop_idle_rd_en", rd_en_cnt, 8);
    check("endrop_idle_valid", 32'(s_valid), 32'd0);

    // Back-to-back frames
    clear_logs();
    push_frame();
    push_frame();
    enable = 1'b1;
    for (int i = 0; i < 60 && beat_cyc.size() < 9; i++) tick();
    enable = 1'b0;
    drain("b2b_drain");
    check("b2b_beats", beat_cyc.size(), 16);
    check("b2b_gap_le4", 32'((beat_cyc[8] - beat_cyc[7]) <= 4), 32'd1);
    check("b2b_frame_done", fd_cyc.size(), 2);
    check("b2b_rd_en", rd_en_cnt, 16);

    // Reset asserted at beat 5
    clear_logs();
    push_frame();
    enable = 1'b1;
    for (int i = 0; i < 40 && beat_cyc.size() < 5; i++) tick();
    check("midrst_beats_before", beat_cyc.size(), 5);
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_sop", 32'(sop_out), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_rd_en", 32'(rd_en), 32'd0);
    check("midrst_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    clear_logs();
    repeat (2) tick();
    check("midrst_quiet", beat_cyc.size(), 0);
    push_frame();
    reset = 1'b1;
    wait_rd_en("midrst_restart");
    enable = 1'b0;
    drain("midrst_drain");
    check("midrst_after_beats", beat_cyc.size(), 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
